// File: rtl/clk_div_gen_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package clk_pkg;

   // Counter/divisor width carried by the configuration record.
   localparam int CNT_W_DEF = 8;

   // Smallest legal divisor; a requested divisor of zero is raised to this.
   localparam int DIV_MIN = 1;

   // One channel configuration: divisor and phase-tick position.
   typedef struct packed {
      logic [CNT_W_DEF-1:0] div;
      logic [CNT_W_DEF-1:0] phase;
   } cfg_t;

   // Channel-select width; a single channel still needs one select bit.
   function automatic int ch_w_f(input int num_ch);
      if (num_ch <= 1) begin
         return 1;
      end else begin
         return $clog2(num_ch);
      end
   endfunction

endpackage

// File: rtl/clk_div_gen_if.sv
// Configuration request bus of the clock divider (valid/ready handshake plus error pulse).
interface clk_div_gen_if
   import clk_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = CNT_W_DEF
) ();

   localparam int CH_W = ch_w_f(NUM_CH);

   logic             i_cfg_vld;
   logic             o_cfg_rdy;
   logic [CH_W-1:0]  i_cfg_ch;
   logic [CNT_W-1:0] i_cfg_div;
   logic [CNT_W-1:0] i_cfg_phase;
   logic             o_cfg_err;

   modport master (
      output i_cfg_vld, i_cfg_ch, i_cfg_div, i_cfg_phase,
      input  o_cfg_rdy, o_cfg_err
   );

   modport slave (
      input  i_cfg_vld, i_cfg_ch, i_cfg_div, i_cfg_phase,
      output o_cfg_rdy, o_cfg_err
   );

endinterface

// File: rtl/clk_div_gen_ch.sv
// One divider channel: period counter, single-entry pending config slot,
// boundary-only apply, and output flops aligned with the counter value.
module clk_div_ch
   import clk_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int DIV_DEFAULT = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_ld,
   input  cfg_t i_cfg,
   output logic o_pend,
   output logic o_clk_div,
   output logic o_tick,
   output logic o_ph_tick
);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] div_r;
   logic [CNT_W-1:0] phase_r;
   cfg_t             pend_r;
   logic             pend_vld_r;
   logic             run_r;
   logic             clk_div_r;
   logic             tick_r;
   logic             ph_tick_r;

   logic             wrap_s;
   logic             apply_s;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [CNT_W-1:0] div_nxt_s;
   logic [CNT_W-1:0] phase_nxt_s;
   logic [CNT_W:0]   hi_sum_s;
   logic [CNT_W:0]   hi_nxt_s;
   logic             clk_div_nxt_s;
   logic             tick_nxt_s;
   logic             ph_tick_nxt_s;

   // Next counter/config and the output values that belong to the next count.
   always_comb begin
      wrap_s  = (cnt_r == (div_r - CNT_W'(1'b1)));
      // A disabled or just-starting channel is always at a period boundary.
      apply_s = pend_vld_r & (~i_en | ~run_r | wrap_s);

      if (apply_s) begin
         div_nxt_s   = pend_r.div;
         phase_nxt_s = pend_r.phase;
      end else begin
         div_nxt_s   = div_r;
         phase_nxt_s = phase_r;
      end

      if (!i_en) begin
         cnt_nxt_s = {CNT_W{1'b0}};
      end else if (!run_r || wrap_s) begin
         cnt_nxt_s = {CNT_W{1'b0}};
      end else begin
         cnt_nxt_s = cnt_r + CNT_W'(1'b1);
      end

      // High time (div+1)/2, one bit wider so the largest divisor cannot overflow.
      hi_sum_s      = {1'b0, div_nxt_s} + {{CNT_W{1'b0}}, 1'b1};
      hi_nxt_s      = {1'b0, hi_sum_s[CNT_W:1]};
      clk_div_nxt_s = i_en & ({1'b0, cnt_nxt_s} < hi_nxt_s);
      tick_nxt_s    = i_en & (cnt_nxt_s == (div_nxt_s - CNT_W'(1'b1)));
      ph_tick_nxt_s = i_en & (cnt_nxt_s == phase_nxt_s);
   end

   // Counter, active configuration and output flops.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_r     <= {CNT_W{1'b0}};
         div_r     <= CNT_W'(DIV_DEFAULT);
         phase_r   <= {CNT_W{1'b0}};
         run_r     <= 1'b0;
         clk_div_r <= 1'b0;
         tick_r    <= 1'b0;
         ph_tick_r <= 1'b0;
      end else begin
         cnt_r     <= cnt_nxt_s;
         div_r     <= div_nxt_s;
         phase_r   <= phase_nxt_s;
         run_r     <= i_en;
         clk_div_r <= clk_div_nxt_s;
         tick_r    <= tick_nxt_s;
         ph_tick_r <= ph_tick_nxt_s;
      end
   end

   // Pending slot: filled on accept, emptied when its value is applied.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pend_vld_r <= 1'b0;
         pend_r     <= '0;
      end else if (i_ld) begin
         pend_vld_r <= 1'b1;
         pend_r     <= i_cfg;
      end else if (apply_s) begin
         pend_vld_r <= 1'b0;
      end else begin
         pend_vld_r <= pend_vld_r;
      end
   end

   assign o_pend    = pend_vld_r;
   assign o_clk_div = clk_div_r;
   assign o_tick    = tick_r;
   assign o_ph_tick = ph_tick_r;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider: config demux, ready mux,
// illegal-value clamping and one divider instance per channel.
module clk_div_gen
   import clk_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int DIV_DEFAULT = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NUM_CH-1:0] i_ch_en,
   clk_div_gen_if.slave      cfg,
   output logic [NUM_CH-1:0] o_clk_div,
   output logic [NUM_CH-1:0] o_tick,
   output logic [NUM_CH-1:0] o_ph_tick
);

   localparam int CH_W     = ch_w_f(NUM_CH);
   localparam int NUM_SLOT = 2 ** CH_W;

   logic [NUM_CH-1:0]   pend_s;
   logic [NUM_CH-1:0]   ld_s;
   logic [NUM_SLOT-1:0] busy_s;
   logic                rdy_s;
   logic                acc_s;
   logic                err_s;
   logic                err_r;
   logic [CNT_W-1:0]    div_cl_s;
   logic [CNT_W-1:0]    phase_cl_s;
   cfg_t                cfg_cl_s;

   // Ready mux; unpopulated channel codes read as busy so they are never accepted.
   always_comb begin
      busy_s             = {NUM_SLOT{1'b1}};
      busy_s[NUM_CH-1:0] = pend_s;
      rdy_s              = ~busy_s[cfg.i_cfg_ch];
      acc_s              = cfg.i_cfg_vld & rdy_s;
   end

   // Clamp illegal requests; the clamped record is what the channel stores.
   always_comb begin
      if (cfg.i_cfg_div == {CNT_W{1'b0}}) begin
         div_cl_s = CNT_W'(DIV_MIN);
      end else begin
         div_cl_s = cfg.i_cfg_div;
      end

      if (cfg.i_cfg_phase >= div_cl_s) begin
         phase_cl_s = div_cl_s - CNT_W'(1'b1);
      end else begin
         phase_cl_s = cfg.i_cfg_phase;
      end

      err_s          = (cfg.i_cfg_div == {CNT_W{1'b0}}) | (cfg.i_cfg_phase >= cfg.i_cfg_div);
      cfg_cl_s.div   = div_cl_s;
      cfg_cl_s.phase = phase_cl_s;
   end

   // Route an accepted request to the selected channel's pending slot.
   always_comb begin
      ld_s = {NUM_CH{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
         ld_s[c] = acc_s & (cfg.i_cfg_ch == CH_W'(c));
      end
   end

   // Error pulse in the cycle after an accept that needed clamping.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         err_r <= 1'b0;
      end else begin
         err_r <= acc_s & err_s;
      end
   end

   assign cfg.o_cfg_rdy = rdy_s;
   assign cfg.o_cfg_err = err_r;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_div_ch #(
         .CNT_W       (CNT_W),
         .DIV_DEFAULT (DIV_DEFAULT)
      ) u_ch (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_en      (i_ch_en[g]),
         .i_ld      (ld_s[g]),
         .i_cfg     (cfg_cl_s),
         .o_pend    (pend_s[g]),
         .o_clk_div (o_clk_div[g]),
         .o_tick    (o_tick[g]),
         .o_ph_tick (o_ph_tick[g])
      );
   end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: table of configurations plus
// hand-written reconfiguration, handshake and reset sequences.
module tb_clk_div_gen;
   import clk_pkg::*;

   localparam int NUM_CH      = 4;
   localparam int CNT_W       = 8;
   localparam int DIV_DEFAULT = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] clk_div;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] ph_tick;

   clk_div_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cif ();

   clk_div_gen #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .DIV_DEFAULT (DIV_DEFAULT)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_ch_en   (en),
      .cfg       (cif),
      .o_clk_div (clk_div),
      .o_tick    (tick),
      .o_ph_tick (ph_tick)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      int         ch;
      logic [2:0] exp;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      int   div;
      int   ph;
      int   exp_div;
      int   exp_ph;
      logic exp_err;
   } vec_t;
   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected {clk_div, tick, ph_tick} in the cycle where the count is k.
   function automatic logic [2:0] exp_f(input int k, input int d, input int p);
      int hi;
      hi = (d + 1) / 2;
      return {(k < hi), (k == d - 1), (k == p)};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int ch, input int k, input int d, input int p);
      sb_t e;
      e.ch  = ch;
      e.exp = exp_f(k, d, p);
      sb_q.push_back(e);
   endtask

   task automatic push_run(input int ch, input int d, input int p, input int k0, input int n);
      for (int i = 0; i < n; i++) begin
         push_exp(ch, (k0 + i) % d, d, p);
      end
   endtask

   task automatic step_sb();
      sb_t e;
      cyc();
      e = sb_q.pop_front();
      chk($sformatf("wave_ch%0d", e.ch),
          32'({clk_div[e.ch], tick[e.ch], ph_tick[e.ch]}), 32'(e.exp));
   endtask

   task automatic drain();
      while (sb_q.size() > 0) begin
         step_sb();
      end
   endtask

   task automatic cfg_drive(input int ch, input int d, input int p);
      cif.i_cfg_vld   = 1'b1;
      cif.i_cfg_ch    = ch[1:0];
      cif.i_cfg_div   = d[7:0];
      cif.i_cfg_phase = p[7:0];
   endtask

   // Configure disabled channel 0, then enable it and check two full periods.
   task automatic run_vec(input vec_t v);
      cfg_drive(0, v.div, v.ph);
      #1;
      chk($sformatf("rdy_free_d%0d", v.div), 32'(cif.o_cfg_rdy), 32'd1);
      cyc();
      cif.i_cfg_vld = 1'b0;
      chk($sformatf("err_d%0d_p%0d", v.div, v.ph), 32'(cif.o_cfg_err), 32'(v.exp_err));
      chk($sformatf("rdy_busy_d%0d", v.div), 32'(cif.o_cfg_rdy), 32'd0);
      cyc();
      chk($sformatf("err_clear_d%0d", v.div), 32'(cif.o_cfg_err), 32'd0);
      chk($sformatf("rdy_applied_d%0d", v.div), 32'(cif.o_cfg_rdy), 32'd1);
      en[0] = 1'b1;
      push_run(0, v.exp_div, v.exp_ph, 0, 2 * v.exp_div);
      drain();
      en[0] = 1'b0;
      cyc();
      chk($sformatf("disable_d%0d", v.div), 32'({clk_div[0], tick[0], ph_tick[0]}), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst             = 1'b1;
      en              = '0;
      cif.i_cfg_vld   = 1'b0;
      cif.i_cfg_ch    = '0;
      cif.i_cfg_div   = '0;
      cif.i_cfg_phase = '0;

      vecs[0] = '{4,   0,   4,   0,   1'b0};
      vecs[1] = '{5,   0,   5,   0,   1'b0};
      vecs[2] = '{1,   0,   1,   0,   1'b0};
      vecs[3] = '{3,   2,   3,   2,   1'b0};
      vecs[4] = '{0,   0,   1,   0,   1'b1};
      vecs[5] = '{4,   7,   4,   3,   1'b1};
      vecs[6] = '{255, 254, 255, 254, 1'b0};

      cyc();
      cyc();
      chk("rst_clk_div", 32'(clk_div), 32'd0);
      chk("rst_tick",    32'(tick),    32'd0);
      chk("rst_ph_tick", 32'(ph_tick), 32'd0);
      chk("rst_err",     32'(cif.o_cfg_err), 32'd0);
      for (int c = 0; c < NUM_CH; c++) begin
         cif.i_cfg_ch = c[1:0];
         #1;
         chk($sformatf("rst_rdy_ch%0d", c), 32'(cif.o_cfg_rdy), 32'd1);
      end
      cif.i_cfg_ch = '0;
      rst = 1'b0;

      // Reset divisor (2, phase 0) on a channel that was never configured.
      en = 4'b0100;
      push_run(2, DIV_DEFAULT, 0, 0, 4);
      drain();
      en = 4'b0000;
      cyc();
      chk("disable_ch2", 32'({clk_div[2], tick[2], ph_tick[2]}), 32'd0);

      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i]);
      end

      // Mid-period reconfiguration with a second channel accepted in the same window.
      cfg_drive(0, 4, 1);
      cyc();
      cif.i_cfg_vld = 1'b0;
      cyc();
      en = 4'b0001;
      push_run(0, 4, 1, 0, 2);
      drain();
      cfg_drive(0, 6, 3);
      push_exp(0, 2, 4, 1);
      step_sb();
      chk("reconf_err", 32'(cif.o_cfg_err), 32'd0);
      cfg_drive(0, 2, 0);
      #1;
      chk("rdy_held_same_ch", 32'(cif.o_cfg_rdy), 32'd0);
      cfg_drive(1, 3, 0);
      #1;
      chk("rdy_other_ch", 32'(cif.o_cfg_rdy), 32'd1);
      push_exp(0, 3, 4, 1);
      step_sb();
      cif.i_cfg_vld = 1'b0;
      cif.i_cfg_ch  = 2'd0;
      #1;
      chk("rdy_before_apply", 32'(cif.o_cfg_rdy), 32'd0);
      push_exp(0, 0, 6, 3);
      step_sb();
      chk("rdy_after_apply", 32'(cif.o_cfg_rdy), 32'd1);
      push_run(0, 6, 3, 1, 11);
      drain();

      en = 4'b0011;
      push_run(1, 3, 0, 0, 6);
      drain();
      en = 4'b0001;

      // Reset while running with a pending config on the same channel.
      cfg_drive(0, 5, 0);
      cyc();
      cif.i_cfg_vld = 1'b0;
      chk("rdy_pending_pre_rst", 32'(cif.o_cfg_rdy), 32'd0);
      rst = 1'b1;
      cyc();
      chk("rst2_clk_div", 32'(clk_div), 32'd0);
      chk("rst2_tick",    32'(tick),    32'd0);
      chk("rst2_ph_tick", 32'(ph_tick), 32'd0);
      chk("rst2_err",     32'(cif.o_cfg_err), 32'd0);
      chk("rst2_rdy",     32'(cif.o_cfg_rdy), 32'd1);
      rst = 1'b0;
      push_run(0, DIV_DEFAULT, 0, 0, 4);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
